// File: rtl/score_display_pkg.sv
// Shared definitions for the score display: FSM encoding, special glyphs and
// the seven-segment lookup used by every digit decoder.
package score_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;

    // Active-low segments, bit 0 = a through bit 6 = g.
    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/score_display_seg7_glyph.sv
// Single-digit combinational decoder from a 4-bit value to active-low segments.
module seg7_glyph
    import score_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = hex_glyph(digit);

endmodule

// File: rtl/score_display.sv
// Multi-digit seven-segment score display: captures a binary value, converts it
// to hex or BCD digits, applies leading-zero blanking/overflow dashes and blink.
module score_display
    import score_display_pkg::*;
#(
    parameter int BIN_W      = 16,
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_W    = 24
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [BIN_W-1:0]        value,
    input  logic                    load,
    input  logic                    mode_dec,
    input  logic                    blank_lz,
    input  logic                    blink,
    output logic                    ready,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] HEX
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam longint unsigned DEC_LIMIT = pow10(NUM_DIGITS);

    state_t                  state, next_state;
    logic [BIN_W-1:0]        val_q, shift_q;
    logic                    dec_q, blz_q;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DW-1:0]           bcd_q, bcd_adj;
    logic [DW-1:0]           digit_src;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    nz_seen;
    logic [7*NUM_DIGITS-1:0] glyphs, disp_next, disp_q;
    logic                    hex_ovf, ovf_next, ovf_q;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    phase;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load) next_state = mode_dec ? CONVERT : UPDATE;
            CONVERT: if (bit_cnt == CNT_W'(BIN_W - 1)) next_state = UPDATE;
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    // Double-dabble: adjust every BCD digit, then shift in the next binary bit.
    // Digits above NUM_DIGITS are dropped; their loss is reported as overflow.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            val_q   <= '0;
            shift_q <= '0;
            dec_q   <= 1'b0;
            blz_q   <= 1'b0;
            bit_cnt <= '0;
            bcd_q   <= '0;
            disp_q  <= {NUM_DIGITS{GLYPH_BLANK}};
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        val_q   <= value;
                        shift_q <= value;
                        dec_q   <= mode_dec;
                        blz_q   <= blank_lz;
                        bit_cnt <= '0;
                        bcd_q   <= '0;
                    end
                end
                CONVERT: begin
                    bcd_q   <= {bcd_adj[DW-2:0], shift_q[BIN_W-1]};
                    shift_q <= shift_q << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                UPDATE: begin
                    disp_q <= disp_next;
                    ovf_q  <= ovf_next;
                end
                default: ;
            endcase
        end
    end

    generate
        if (BIN_W > DW) begin : g_hex_ovf
            assign hex_ovf = |val_q[BIN_W-1:DW];
        end else begin : g_no_hex_ovf
            assign hex_ovf = 1'b0;
        end
    endgenerate

    assign digit_src = dec_q ? bcd_q : DW'(val_q);
    assign ovf_next  = dec_q ? (64'(val_q) >= DEC_LIMIT) : hex_ovf;

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
            seg7_glyph u_glyph (
                .digit (digit_src[4*g +: 4]),
                .seg   (glyphs[7*g +: 7])
            );
        end
    endgenerate

    // Walk from the most significant digit down; blank zeros until the first non-zero.
    always_comb begin
        lz_mask = '0;
        nz_seen = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nz_seen    = nz_seen | (digit_src[4*k +: 4] != 4'd0);
            lz_mask[k] = blz_q && !nz_seen && (k != 0);
        end
    end

    always_comb begin
        disp_next = {NUM_DIGITS{GLYPH_BLANK}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (ovf_next)        disp_next[7*k +: 7] = GLYPH_DASH;
            else if (lz_mask[k]) disp_next[7*k +: 7] = GLYPH_BLANK;
            else                 disp_next[7*k +: 7] = glyphs[7*k +: 7];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if (&blink_cnt) phase <= ~phase;
        end
    end

    assign overflow = ovf_q;
    assign HEX      = (blink && !phase) ? {NUM_DIGITS{GLYPH_BLANK}} : disp_q;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: a six-digit and a two-digit instance
// share stimulus and are checked against an arithmetic model of the display.
module tb_score_display;

    localparam int BIN_W   = 16;
    localparam int ND_A    = 6;
    localparam int ND_B    = 2;
    localparam int BLINK_W = 3;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic             clock = 1'b0;
    logic             reset;
    logic [BIN_W-1:0] value;
    logic             load, mode_dec, blank_lz, blink;
    logic             ready_a, ovf_a, ready_b, ovf_b;
    logic [41:0]      hex_a;
    logic [13:0]      hex_b;

    int          assertions = 0;
    int          failures   = 0;
    int          edges;
    logic [41:0] exp_disp_a;
    logic [13:0] exp_disp_b;
    logic        exp_ovf_a, exp_ovf_b;

    score_display #(.BIN_W(BIN_W), .NUM_DIGITS(ND_A), .BLINK_W(BLINK_W)) dut_a (
        .clock(clock), .reset(reset), .value(value), .load(load),
        .mode_dec(mode_dec), .blank_lz(blank_lz), .blink(blink),
        .ready(ready_a), .overflow(ovf_a), .HEX(hex_a)
    );

    score_display #(.BIN_W(BIN_W), .NUM_DIGITS(ND_B), .BLINK_W(BLINK_W)) dut_b (
        .clock(clock), .reset(reset), .value(value), .load(load),
        .mode_dec(mode_dec), .blank_lz(blank_lz), .blink(blink),
        .ready(ready_b), .overflow(ovf_b), .HEX(hex_b)
    );

    always #5 clock = ~clock;

    // Clock edges since reset release; the blink phase follows as (edges / 2^BLINK_W) mod 2.
    always @(posedge clock or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    function automatic logic [41:0] model_disp(input int v, input bit dec, input bit blz, input int nd);
        longint pw   = 1;
        longint lim  = 1;
        int     base = dec ? 10 : 16;
        logic [41:0] r = '0;
        for (int k = 0; k < nd; k++) lim = lim * base;
        for (int k = 0; k < nd; k++) begin
            if (v >= lim)                    r[7*k +: 7] = 7'h3F;
            else if (blz && k > 0 && v < pw) r[7*k +: 7] = 7'h7F;
            else                             r[7*k +: 7] = GLYPH[int'((v / pw) % base)];
            pw = pw * base;
        end
        return r;
    endfunction

    function automatic bit model_ovf(input int v, input bit dec, input int nd);
        longint lim = 1;
        for (int k = 0; k < nd; k++) lim = lim * (dec ? 10 : 16);
        return v >= lim;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkDisplay(input string tag);
        bit          blank_now;
        logic [41:0] ea;
        logic [13:0] eb;
        blank_now = blink && ((edges / (1 << BLINK_W)) % 2 == 0);
        ea = blank_now ? '1 : exp_disp_a;
        eb = blank_now ? '1 : exp_disp_b;
        checkOutput({tag, "_hex_a"}, hex_a, ea);
        checkOutput({tag, "_hex_b"}, hex_b, eb);
        checkOutput({tag, "_ovf_a"}, ovf_a, exp_ovf_a);
        checkOutput({tag, "_ovf_b"}, ovf_b, exp_ovf_b);
    endtask

    task automatic applyStimulus(input logic [BIN_W-1:0] v, input bit dec, input bit blz, input int extra_at);
        int          n    = 0;
        int          want = dec ? BIN_W + 1 : 1;
        logic [41:0] tmp;
        @(negedge clock);
        value = v; mode_dec = dec; blank_lz = blz; load = 1'b1;
        @(posedge clock);
        @(negedge clock);
        load = 1'b0;
        while (!ready_a && n < 40) begin
            n++;
            checkDisplay("busy_hold");
            if (n == extra_at) begin
                value = 16'd4321; mode_dec = 1'b0; blank_lz = 1'b0; load = 1'b1;
            end
            @(negedge clock);
            load = 1'b0;
        end
        checkOutput("ready_low_cycles", n, want);
        checkOutput("ready_b_idle", ready_b, 1'b1);
        exp_disp_a = model_disp(int'(v), dec, blz, ND_A);
        tmp        = model_disp(int'(v), dec, blz, ND_B);
        exp_disp_b = tmp[13:0];
        exp_ovf_a  = model_ovf(int'(v), dec, ND_A);
        exp_ovf_b  = model_ovf(int'(v), dec, ND_B);
        checkDisplay("result");
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; value = '0; mode_dec = 1'b0; blank_lz = 1'b0; blink = 1'b0;
        exp_disp_a = '1; exp_disp_b = '1; exp_ovf_a = 1'b0; exp_ovf_b = 1'b0;
        #12;
        checkDisplay("reset");
        checkOutput("reset_ready", ready_a, 1'b1);
        @(negedge clock);
        reset = 1'b0;

        applyStimulus(16'hBEEF, 1'b0, 1'b0, 0);
        checkOutput("beef_digits", hex_a, {7'h40, 7'h40, 7'h03, 7'h06, 7'h06, 7'h0E});

        applyStimulus(16'd1259, 1'b1, 1'b1, 0);
        checkOutput("dec1259_digits", hex_a, {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h12, 7'h10});

        applyStimulus(16'd0, 1'b1, 1'b1, 5);
        checkOutput("zero_digits", hex_a, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("no_queued_load", ready_a, 1'b1);
        end

        applyStimulus(16'd100, 1'b1, 1'b0, 0);
        checkOutput("two_digit_ovf", ovf_b, 1'b1);
        checkOutput("two_digit_dash", hex_b, {7'h3F, 7'h3F});

        blink = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            checkDisplay("blink");
        end
        blink = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checkDisplay("steady");
        end

        for (int i = 0; i < 24; i++) begin
            logic [BIN_W-1:0] v;
            v = ($urandom_range(0, 3) == 0) ? BIN_W'($urandom_range(0, 300)) : BIN_W'($urandom_range(0, 65535));
            blink = ($urandom_range(0, 3) == 0);
            applyStimulus(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        blink = 1'b0;

        @(negedge clock);
        value = 16'd54321; mode_dec = 1'b1; blank_lz = 1'b0; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        repeat (4) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        exp_disp_a = '1; exp_disp_b = '1; exp_ovf_a = 1'b0; exp_ovf_b = 1'b0;
        checkDisplay("reset_mid");
        checkOutput("reset_mid_ready", ready_a, 1'b1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checkDisplay("after_abort");
        end

        applyStimulus(16'd987, 1'b1, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
